// File: rtl/dispatch_stage.sv
// Dispatch stage: one-entry holding slot between decode and the OoO back end.
// Operands keep snooping the CDB while held and are bypassed again on the way out.
module dispatch_stage #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ROB_W  = 4,
  parameter int unsigned OP_W   = 6,
  parameter int unsigned N_CDB  = 2,
  parameter int unsigned OP_NOP = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [OP_W-1:0]         in_op,
  input  logic                    in_is_mem,
  input  logic                    in_is_jump,
  input  logic                    in_is_store,
  input  logic                    in_pred_jump,
  input  logic [4:0]              in_rd,
  input  logic [XLEN-1:0]         in_pc,
  input  logic [XLEN-1:0]         in_imm,
  input  logic [ROB_W-1:0]        in_q1,
  input  logic [ROB_W-1:0]        in_q2,
  input  logic [XLEN-1:0]         in_v1,
  input  logic [XLEN-1:0]         in_v2,
  input  logic [N_CDB-1:0]        cdb_valid,
  input  logic [N_CDB*ROB_W-1:0]  cdb_tag,
  input  logic [N_CDB*XLEN-1:0]   cdb_data,
  input  logic                    rob_full,
  input  logic                    rs_full,
  input  logic                    lsb_full,
  input  logic [ROB_W-1:0]        rob_tag,
  output logic                    ena_to_rob,
  output logic                    ena_to_rs,
  output logic                    ena_to_lsb,
  output logic                    ena_to_reg,
  output logic [OP_W-1:0]         out_op,
  output logic [4:0]              out_rd,
  output logic [XLEN-1:0]         out_pc,
  output logic [XLEN-1:0]         out_imm,
  output logic [ROB_W-1:0]        out_q1,
  output logic [ROB_W-1:0]        out_q2,
  output logic [XLEN-1:0]         out_v1,
  output logic [XLEN-1:0]         out_v2,
  output logic [ROB_W-1:0]        out_tag,
  output logic                    out_is_jump,
  output logic                    out_is_store,
  output logic                    out_pred_jump,
  output logic [31:0]             stall_cnt
);

  localparam logic [OP_W-1:0] L_OP_NOP = OP_W'(OP_NOP);

  // Returns {tag, value}; a tag hit on the CDB clears the tag, lowest channel wins.
  function automatic logic [ROB_W+XLEN-1:0] fwd(
    input logic [ROB_W-1:0]       q,
    input logic [XLEN-1:0]        v,
    input logic [N_CDB-1:0]       vld,
    input logic [N_CDB*ROB_W-1:0] tags,
    input logic [N_CDB*XLEN-1:0]  data
  );
    logic [ROB_W+XLEN-1:0] res;
    logic                  hit;
    res = {q, v};
    hit = 1'b0;
    for (int i = 0; i < N_CDB; i++) begin
      if (!hit && (q != '0) && vld[i] && (tags[i*ROB_W +: ROB_W] == q)) begin
        res = {{ROB_W{1'b0}}, data[i*XLEN +: XLEN]};
        hit = 1'b1;
      end
    end
    return res;
  endfunction

  logic                r_valid;
  logic [OP_W-1:0]     r_op;
  logic                r_is_mem;
  logic                r_is_jump;
  logic                r_is_store;
  logic                r_pred_jump;
  logic [4:0]          r_rd;
  logic [XLEN-1:0]     r_pc;
  logic [XLEN-1:0]     r_imm;
  logic [ROB_W-1:0]    r_q1;
  logic [ROB_W-1:0]    r_q2;
  logic [XLEN-1:0]     r_v1;
  logic [XLEN-1:0]     r_v2;
  logic [31:0]         r_stall_cnt;

  logic                w_tgt_full;
  logic                w_fire;
  logic                w_ready;
  logic                w_accept;
  logic                w_stall;
  logic [ROB_W+XLEN-1:0] w_hold_fwd1;
  logic [ROB_W+XLEN-1:0] w_hold_fwd2;
  logic [ROB_W+XLEN-1:0] w_in_fwd1;
  logic [ROB_W+XLEN-1:0] w_in_fwd2;

  assign w_tgt_full  = r_is_mem ? lsb_full : rs_full;
  assign w_fire      = rdy & ~flush & ~rst & r_valid & ~rob_full & ~w_tgt_full;
  assign w_ready     = rdy & ~flush & ~rst & (~r_valid | w_fire);
  assign w_accept    = in_valid & w_ready;
  assign w_stall     = r_valid & ~w_fire;

  assign w_hold_fwd1 = fwd(r_q1, r_v1, cdb_valid, cdb_tag, cdb_data);
  assign w_hold_fwd2 = fwd(r_q2, r_v2, cdb_valid, cdb_tag, cdb_data);
  assign w_in_fwd1   = fwd(in_q1, in_v1, cdb_valid, cdb_tag, cdb_data);
  assign w_in_fwd2   = fwd(in_q2, in_v2, cdb_valid, cdb_tag, cdb_data);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid     <= 1'b0;
      r_op        <= '0;
      r_is_mem    <= 1'b0;
      r_is_jump   <= 1'b0;
      r_is_store  <= 1'b0;
      r_pred_jump <= 1'b0;
      r_rd        <= '0;
      r_pc        <= '0;
      r_imm       <= '0;
      r_q1        <= '0;
      r_q2        <= '0;
      r_v1        <= '0;
      r_v2        <= '0;
      r_stall_cnt <= '0;
    end else if (rdy) begin
      if (flush) begin
        r_valid <= 1'b0;
      end else begin
        if (w_accept && (in_op != L_OP_NOP)) begin
          r_valid     <= 1'b1;
          r_op        <= in_op;
          r_is_mem    <= in_is_mem;
          r_is_jump   <= in_is_jump;
          r_is_store  <= in_is_store;
          r_pred_jump <= in_pred_jump;
          r_rd        <= in_rd;
          r_pc        <= in_pc;
          r_imm       <= in_imm;
          {r_q1, r_v1} <= w_in_fwd1;
          {r_q2, r_v2} <= w_in_fwd2;
        end else if (w_accept || w_fire) begin
          // A NOP is swallowed here; the slot was either empty or just fired.
          r_valid <= 1'b0;
        end else if (r_valid) begin
          {r_q1, r_v1} <= w_hold_fwd1;
          {r_q2, r_v2} <= w_hold_fwd2;
        end
        if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
          r_stall_cnt <= r_stall_cnt + 32'd1;
        end
      end
    end
  end

  assign in_ready      = w_ready;
  assign ena_to_rob    = w_fire;
  assign ena_to_lsb    = w_fire & r_is_mem;
  assign ena_to_rs     = w_fire & ~r_is_mem;
  assign ena_to_reg    = w_fire & (r_rd != 5'd0);

  assign out_op        = r_op;
  assign out_rd        = r_rd;
  assign out_pc        = r_pc;
  assign out_imm       = r_imm;
  assign {out_q1, out_v1} = w_hold_fwd1;
  assign {out_q2, out_v2} = w_hold_fwd2;
  assign out_tag       = rob_tag;
  assign out_is_jump   = r_is_jump;
  assign out_is_store  = r_is_store;
  assign out_pred_jump = r_pred_jump;
  assign stall_cnt     = r_stall_cnt;

endmodule

// File: tb/tb_dispatch_stage.sv
// Self-checking bench for dispatch_stage: directed scenarios then random traffic,
// every cycle compared against a queue-based reference of the held instruction.
module tb_dispatch_stage;
  localparam int XLEN  = 32;
  localparam int ROB_W = 4;
  localparam int OP_W  = 6;
  localparam int N_CDB = 2;
  localparam logic [OP_W-1:0] NOP = '0;

  logic clk = 1'b0;
  logic rst, rdy, flush, in_valid, in_ready;
  logic [OP_W-1:0] in_op;
  logic in_is_mem, in_is_jump, in_is_store, in_pred_jump;
  logic [4:0] in_rd;
  logic [XLEN-1:0] in_pc, in_imm, in_v1, in_v2;
  logic [ROB_W-1:0] in_q1, in_q2;
  logic [N_CDB-1:0] cdb_valid;
  logic [N_CDB*ROB_W-1:0] cdb_tag;
  logic [N_CDB*XLEN-1:0] cdb_data;
  logic rob_full, rs_full, lsb_full;
  logic [ROB_W-1:0] rob_tag;
  logic ena_to_rob, ena_to_rs, ena_to_lsb, ena_to_reg;
  logic [OP_W-1:0] out_op;
  logic [4:0] out_rd;
  logic [XLEN-1:0] out_pc, out_imm, out_v1, out_v2;
  logic [ROB_W-1:0] out_q1, out_q2, out_tag;
  logic out_is_jump, out_is_store, out_pred_jump;
  logic [31:0] stall_cnt;

  dispatch_stage #(.XLEN(XLEN), .ROB_W(ROB_W), .OP_W(OP_W), .N_CDB(N_CDB), .OP_NOP(0)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_is_mem(in_is_mem),
    .in_is_jump(in_is_jump), .in_is_store(in_is_store), .in_pred_jump(in_pred_jump),
    .in_rd(in_rd), .in_pc(in_pc), .in_imm(in_imm), .in_q1(in_q1), .in_q2(in_q2),
    .in_v1(in_v1), .in_v2(in_v2), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full), .rob_tag(rob_tag),
    .ena_to_rob(ena_to_rob), .ena_to_rs(ena_to_rs), .ena_to_lsb(ena_to_lsb), .ena_to_reg(ena_to_reg),
    .out_op(out_op), .out_rd(out_rd), .out_pc(out_pc), .out_imm(out_imm),
    .out_q1(out_q1), .out_q2(out_q2), .out_v1(out_v1), .out_v2(out_v2), .out_tag(out_tag),
    .out_is_jump(out_is_jump), .out_is_store(out_is_store), .out_pred_jump(out_pred_jump),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic             is_mem, is_jump, is_store, pred;
    logic [4:0]       rd;
    logic [XLEN-1:0]  pc, imm;
    logic [ROB_W-1:0] q1, q2;
    logic [XLEN-1:0]  v1, v2;
  } instr_t;

  instr_t      held[$];
  longint      stalls = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] base;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  // Operand wakeup: any matching valid broadcast supplies the value, lowest channel first.
  function automatic instr_t wake(input instr_t x);
    instr_t y;
    logic d1, d2;
    y = x; d1 = 1'b0; d2 = 1'b0;
    for (int i = 0; i < N_CDB; i++) begin
      if (!d1 && x.q1 != 0 && cdb_valid[i] && cdb_tag[i*ROB_W +: ROB_W] == x.q1) begin
        y.q1 = '0; y.v1 = cdb_data[i*XLEN +: XLEN]; d1 = 1'b1;
      end
      if (!d2 && x.q2 != 0 && cdb_valid[i] && cdb_tag[i*ROB_W +: ROB_W] == x.q2) begin
        y.q2 = '0; y.v2 = cdb_data[i*XLEN +: XLEN]; d2 = 1'b1;
      end
    end
    return y;
  endfunction

  function automatic logic can_go();
    if (held.size() == 0 || !rdy || flush || rst || rob_full) return 1'b0;
    return held[0].is_mem ? !lsb_full : !rs_full;
  endfunction

  task automatic model_check();
    logic   go;
    instr_t h;
    if (rst) begin
      check("rst_in_ready", in_ready, 0);
      check("rst_ena_rob", ena_to_rob, 0);
      check("rst_ena_rs", ena_to_rs, 0);
      check("rst_ena_lsb", ena_to_lsb, 0);
      check("rst_ena_reg", ena_to_reg, 0);
    end else begin
      go = can_go();
      check("in_ready", in_ready, rdy && !flush && (held.size() == 0 || go));
      check("ena_rob", ena_to_rob, go);
      check("ena_rs", ena_to_rs, go && !held[0].is_mem);
      check("ena_lsb", ena_to_lsb, go && held[0].is_mem);
      check("ena_reg", ena_to_reg, go && held[0].rd != 0);
      check("stall_cnt", stall_cnt, stalls);
      if (go) begin
        h = wake(held[0]);
        check("out_op", out_op, h.op);
        check("out_rd", out_rd, h.rd);
        check("out_pc", out_pc, h.pc);
        check("out_imm", out_imm, h.imm);
        check("out_q1", out_q1, h.q1);
        check("out_v1", out_v1, h.v1);
        check("out_q2", out_q2, h.q2);
        check("out_v2", out_v2, h.v2);
        check("out_tag", out_tag, rob_tag);
        check("out_flags", {out_is_jump, out_is_store, out_pred_jump}, {h.is_jump, h.is_store, h.pred});
      end
    end
  endtask

  task automatic model_update();
    logic   go, acc;
    instr_t ni;
    if (rst) begin
      held.delete();
      stalls = 0;
    end else if (rdy && flush) begin
      held.delete();
    end else if (rdy) begin
      go  = can_go();
      acc = in_valid && (held.size() == 0 || go);
      if (go) begin
        void'(held.pop_front());
      end else if (held.size() > 0) begin
        held[0] = wake(held[0]);
        if (stalls < 64'hFFFF_FFFF) stalls++;
      end
      if (acc && in_op != NOP) begin
        ni = '{op: in_op, is_mem: in_is_mem, is_jump: in_is_jump, is_store: in_is_store,
               pred: in_pred_jump, rd: in_rd, pc: in_pc, imm: in_imm,
               q1: in_q1, q2: in_q2, v1: in_v1, v2: in_v2};
        held.push_back(wake(ni));
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    model_check();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    rst = 0; rdy = 1; flush = 0; in_valid = 0; in_op = 6'd1; in_is_mem = 0;
    in_is_jump = 0; in_is_store = 0; in_pred_jump = 0; in_rd = 0; in_pc = 0; in_imm = 0;
    in_q1 = 0; in_q2 = 0; in_v1 = 0; in_v2 = 0; cdb_valid = 0; cdb_tag = 0; cdb_data = 0;
    rob_full = 0; rs_full = 0; lsb_full = 0; rob_tag = 4'd3;
  endtask

  task automatic set_instr(input logic [OP_W-1:0] op, input logic mem, input logic [4:0] rd,
                           input logic [ROB_W-1:0] q1, input logic [XLEN-1:0] v1,
                           input logic [ROB_W-1:0] q2, input logic [XLEN-1:0] v2);
    in_valid = 1; in_op = op; in_is_mem = mem; in_rd = rd;
    in_is_jump = ($urandom_range(0, 1) == 1);
    in_is_store = mem && ($urandom_range(0, 1) == 1);
    in_pred_jump = ($urandom_range(0, 1) == 1);
    in_pc = $urandom; in_imm = $urandom;
    in_q1 = q1; in_v1 = v1; in_q2 = q2; in_v2 = v2;
  endtask

  task automatic randomize_inputs();
    rst   = ($urandom_range(0, 199) == 0);
    rdy   = ($urandom_range(0, 9) != 0);
    flush = ($urandom_range(0, 19) == 0);
    set_instr(($urandom_range(0, 4) == 0) ? NOP : OP_W'($urandom_range(1, 63)),
              ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 31)),
              ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0, $urandom,
              ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0, $urandom);
    in_valid  = ($urandom_range(0, 3) != 0);
    cdb_valid = N_CDB'($urandom_range(0, 3));
    cdb_tag   = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
    cdb_data  = {$urandom, $urandom};
    rob_full  = ($urandom_range(0, 4) == 0);
    rs_full   = ($urandom_range(0, 3) == 0);
    lsb_full  = ($urandom_range(0, 3) == 0);
    rob_tag   = 4'($urandom_range(0, 15));
  endtask

  initial begin
    idle();
    rst = 1;
    cycle(); cycle();
    rst = 0;
    check("reset_out_pc", out_pc, 0);
    check("reset_out_op", out_op, 0);
    check("reset_out_v1", out_v1, 0);
    check("reset_stall_cnt", stall_cnt, 0);

    // Back-to-back ALU stream: four consecutive fire cycles.
    set_instr(6'd2, 0, 5'd5, 4'd0, 32'd7, 4'd0, 32'd9); cycle();
    for (int k = 0; k < 3; k++) begin
      set_instr(6'd3, 0, 5'(k + 1), 4'd0, $urandom, 4'd0, $urandom); cycle();
    end
    in_valid = 0; cycle(); cycle();

    // Load held off by a full LSB for three cycles.
    lsb_full = 1;
    set_instr(6'd4, 1, 5'd7, 4'd0, 32'h100, 4'd0, 32'h4); cycle();
    in_valid = 0; base = stall_cnt;
    cycle(); cycle(); cycle();
    check("lsb_stall_delta", stall_cnt - base, 3);
    lsb_full = 0; cycle(); cycle();

    // Wakeup while stalled on RS.
    rs_full = 1;
    set_instr(6'd5, 0, 5'd8, 4'd4, 32'h0, 4'd0, 32'h1); cycle();
    in_valid = 0;
    cdb_valid = 2'b10; cdb_tag = {4'd4, 4'd0}; cdb_data = {32'hDEAD, 32'h0}; cycle();
    cdb_valid = 0; rs_full = 0; cycle(); cycle();

    // Accept-cycle bypass on ch0, then fire-cycle bypass on ch1.
    rs_full = 1;
    set_instr(6'd6, 0, 5'd9, 4'd2, 32'h0, 4'd6, 32'h0);
    cdb_valid = 2'b01; cdb_tag = {4'd0, 4'd6}; cdb_data = {32'h0, 32'h55}; cycle();
    in_valid = 0; rs_full = 0;
    cdb_valid = 2'b10; cdb_tag = {4'd2, 4'd0}; cdb_data = {32'hCAFE_F00D, 32'h0}; cycle();
    cdb_valid = 0; cycle();

    // Flush a stalled slot, then freeze a stalled slot with rdy low.
    rs_full = 1;
    set_instr(6'd7, 0, 5'd10, 4'd0, 32'h1, 4'd0, 32'h2); cycle();
    in_valid = 0; cycle();
    base = stall_cnt;
    flush = 1; cycle();
    flush = 0; rs_full = 0; cycle(); cycle();
    check("flush_keeps_stall_cnt", stall_cnt, base);
    rs_full = 1;
    set_instr(6'd8, 0, 5'd11, 4'd0, 32'h3, 4'd0, 32'h4); cycle();
    in_valid = 0; cycle();
    base = stall_cnt;
    rdy = 0; cycle();
    flush = 1; cycle();
    check("rdy_low_stall_cnt", stall_cnt, base);
    rdy = 1; flush = 0; rs_full = 0; cycle(); cycle();

    // NOPs consumed without strobes; rd=0 skips the rename strobe.
    for (int k = 0; k < 3; k++) begin
      set_instr(NOP, 0, 5'd12, 4'd0, 32'h0, 4'd0, 32'h0); cycle();
    end
    set_instr(6'd9, 0, 5'd0, 4'd0, 32'h5, 4'd0, 32'h6); cycle();
    in_valid = 0; cycle(); cycle();

    for (int n = 0; n < 4000; n++) begin
      randomize_inputs();
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/dispatch_stage.md
Name: dispatch_stage

Overview:
- Parametrised dispatch stage between instruction fetch/decode and the out-of-order back end (ROB, RS, LSB, regfile rename).
- Holds one decoded instruction in a holding slot under valid/ready backpressure from ROB/RS/LSB fullness.
- While held, the slot keeps snooping N_CDB broadcast channels so operands wake up during stalls; emitted operands are also bypassed against the same-cycle CDB.
- Supports flush on mispredict and counts dispatch stall cycles.

Parameters:
XLEN, 32, data/address width
ROB_W, 4, ROB tag width; tag 0 = "no dependency / value valid"
OP_W, 6, opcode enum width
N_CDB, 2, number of CDB broadcast channels
OP_NOP, 0, opcode value treated as NOP (consumed, never dispatched)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
rdy  in  1  global enable; low = freeze
flush  in  1  mispredict flush
in_valid  in  1  decoded instruction valid
in_ready  out  1  stage accepts instruction this cycle
in_op  in  OP_W  opcode
in_is_mem  in  1  load/store -> LSB, else RS
in_is_jump, in_is_store, in_pred_jump  in  1 each  ROB flags
in_rd  in  5  destination register
in_pc  in  XLEN  instruction pc
in_imm  in  XLEN  immediate
in_q1, in_q2  in  ROB_W  operand tags from regfile/ROB lookup
in_v1, in_v2  in  XLEN  operand values (valid when tag 0)
cdb_valid  in  N_CDB  per-channel broadcast valid
cdb_tag  in  N_CDB*ROB_W  channel i at [i*ROB_W +: ROB_W]
cdb_data  in  N_CDB*XLEN  channel i at [i*XLEN +: XLEN]
rob_full, rs_full, lsb_full  in  1 each  target cannot accept
rob_tag  in  ROB_W  tag ROB allocates on this cycle's write
ena_to_rob, ena_to_rs, ena_to_lsb, ena_to_reg  out  1 each  dispatch strobes
out_op  out  OP_W;  out_rd  out  5;  out_pc, out_imm  out  XLEN
out_q1, out_q2  out  ROB_W;  out_v1, out_v2  out  XLEN
out_tag  out  ROB_W  = rob_tag, for RS/LSB entry and regfile rename
out_is_jump, out_is_store, out_pred_jump  out  1 each
stall_cnt  out  32  saturating count of stalled cycles

Behaviour:
- State:
  - Slot register S (valid bit plus all in_* fields).
  - stall_cnt.
- Reset:
  - S.valid=0, stall_cnt=0.
  - All strobes 0 and in_ready 0 during the reset cycle.
  - Out data fields reset to 0.
- Forwarding function fwd(q,v):
  - If q!=0 and some channel i has cdb_valid[i] and cdb_tag[i]==q: result is (0, cdb_data[i]), lowest index wins.
  - Otherwise (q,v) unchanged. Tag 0 never matches.
- Fire condition: fire = rdy & !flush & S.valid & !rob_full & (S.is_mem ? !lsb_full : !rs_full).
- Strobes (combinational, zero latency from S):
  - ena_to_rob = fire.
  - ena_to_lsb = fire & S.is_mem.
  - ena_to_rs = fire & !S.is_mem.
  - ena_to_reg = fire & (S.rd!=0).
- Out fields come from S. out_q/out_v = fwd(S.q,S.v), so the same-cycle broadcast is applied. out_tag = rob_tag.
- Ready: in_ready = rdy & !flush & !rst & (!S.valid | fire). This gives full-throughput back-to-back dispatch.
- Posedge update when rdy & !flush:
  - If in_valid & in_ready & in_op!=OP_NOP: S <= inputs with fwd applied to (in_q1,in_v1) and (in_q2,in_v2); S.valid=1.
  - Else if in_valid & in_ready & in_op==OP_NOP: instruction consumed, S.valid <= 0 if it fired.
  - Else if fire: S.valid <= 0.
  - Else if S.valid (stalled): S.q/S.v <= fwd(S.q,S.v). This is the wakeup while held.
- Flush (rdy high): S.valid <= 0, no strobe that cycle, input dropped. stall_cnt is retained.
- rdy low: all state frozen, strobes 0, in_ready 0. Flush is ignored while rdy is low.
- stall_cnt: +1 when rdy & !flush & S.valid & !fire; saturates at 0xFFFFFFFF.
- Simultaneous fire and accept: the outgoing instruction strobes, and the new one occupies S on the same edge.

Test Plan:
- Reset, then ALU op rd=5, q1=0, v1=7, q2=0, v2=9, rs/rob not full, rob_tag=3 -> next cycle ena_to_rs=ena_to_rob=ena_to_reg=1, out_tag=3, out_v1=7, out_v2=9; stream 4 instrs back-to-back -> 4 consecutive fire cycles, in_ready stays 1.
- Load (in_is_mem=1) with lsb_full=1 for 3 cycles -> ena_to_lsb=0 and in_ready=0 for 3 cycles, stall_cnt=3; lsb_full drops -> ena_to_lsb=1 one cycle, ena_to_rs=0.
- Held instr q1=4 stalled on rs_full; cdb channel 1 broadcasts tag 4 data 0xDEAD while stalled -> at dispatch out_q1=0, out_v1=0xDEAD.
- Accept with in_q2=6 while cdb channel 0 broadcasts tag 6 data 0x55 in the same cycle -> S stores q2=0, v2=0x55; then fire-cycle broadcast tag 2 on channel 1 with S.q1=2 -> out_q1=0, out_v1 = channel-1 data.
- Flush while S valid and stalled -> no strobe, S empty next cycle, ena_to_* stay 0; rdy=0 for 2 cycles mid-stall -> no change, stall_cnt unchanged.
- NOP (in_op=OP_NOP) accepted -> no strobes ever, in_ready stays 1; rd=0 instr -> ena_to_reg=0, ena_to_rob=1.
